// File: rtl/dct_pkg.sv
// Shared definitions for the streaming 2-D DCT.
//   - dct_state_e : LOAD / COL / OUT block-level FSM encoding
//   - row_w / full_w / dout_w : datapath widths derived from N, IN_W, COEF_W, OUT_W
//   - dct_coef : elaboration-time DCT-II coefficient generator (Q1.COEF_W-1)
// Configuration macro: DCT_ROUND_EN (rounded, saturated OUT_W-bit output when defined).
package dct_pkg;

   typedef enum logic [1:0] {
      StLoad = 2'd0,
      StCol  = 2'd1,
      StOut  = 2'd2
   } dct_state_e;

`ifdef DCT_ROUND_EN
   localparam bit RoundEn = 1'b1;
`else
   localparam bit RoundEn = 1'b0;
`endif

   localparam real Pi = 3.14159265358979323846;

   // Width of a row-pass result: one extra bit per doubling of terms summed.
   function automatic int row_w(input int n, input int in_w, input int coef_w);
      return in_w + coef_w + $clog2(n);
   endfunction

   // Width of a column-pass result, which consumes row-pass results unchanged.
   function automatic int full_w(input int n, input int in_w, input int coef_w);
      return row_w(n, in_w, coef_w) + coef_w + $clog2(n);
   endfunction

   function automatic int dout_w(input int n, input int in_w, input int coef_w,
                                 input int out_w);
      return RoundEn ? out_w : full_w(n, in_w, coef_w);
   endfunction

   // C[k][n] = round-half-away(2^(coef_w-1) * a(k) * cos((2n+1) k pi / 2N)).
   function automatic int dct_coef(input int n_pts, input int coef_w, input int k, input int n);
      real a;
      real scale;
      real v;
      a     = (k == 0) ? $sqrt(1.0 / n_pts) : $sqrt(2.0 / n_pts);
      scale = 1.0;
      for (int i = 0; i < coef_w - 1; i++) begin
         scale = scale * 2.0;
      end
      v = scale * a * $cos(real'((2 * n + 1) * k) * Pi / real'(2 * n_pts));
      if (v >= 0.0) begin
         return $rtoi(v + 0.5);
      end
      return -$rtoi(0.5 - v);
   endfunction

endpackage

// File: rtl/dct_1d.sv
// Combinational N-point 1-D DCT: o_vec[k] = sum_n C[k][n] * i_vec[n], full precision.
// Ports:
//   i_vec : N signed IN_W-bit samples, element 0 in LSBs
//   o_vec : N signed (IN_W+COEF_W+clog2(N))-bit results, element 0 in LSBs
module dct_1d
   import dct_pkg::*;
#(
   parameter int N      = 8,
   parameter int IN_W   = 9,
   parameter int COEF_W = 12
) (
   input  logic [N*IN_W-1:0]                      i_vec,
   output logic [N*(IN_W+COEF_W+$clog2(N))-1:0]   o_vec
);

   localparam int OW = IN_W + COEF_W + $clog2(N);

   logic signed [IN_W-1:0] w_x    [N];
   logic signed [OW-1:0]   w_prod [N][N];

   for (genvar n = 0; n < N; n++) begin : g_in
      assign w_x[n] = i_vec[n*IN_W +: IN_W];
   end

   for (genvar k = 0; k < N; k++) begin : g_out
      for (genvar n = 0; n < N; n++) begin : g_term
         localparam logic signed [COEF_W-1:0] COEF = COEF_W'(dct_coef(N, COEF_W, k, n));
         // Both operands sign-extended to OW so the product is exact.
         assign w_prod[k][n] = OW'(w_x[n]) * OW'(COEF);
      end

      logic signed [OW-1:0] w_acc;
      always_comb begin
         w_acc = '0;
         for (int n = 0; n < N; n++) begin
            w_acc = w_acc + w_prod[k][n];
         end
      end
      assign o_vec[k*OW +: OW] = w_acc;
   end

endmodule

// File: rtl/dct_2d_stream.sv
// Streaming N x N 2-D DCT. Rows are loaded one per handshake and transformed on entry
// into a transpose buffer; the column pass then runs one column per cycle for N cycles
// into an output buffer, which is drained one coefficient row per handshake.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input row handshake; in_row = N signed IN_W samples
//   out_valid/out_ready  : output row handshake; out_row = N DOUT_W coefficients
//   out_last             : marks row N-1 of a block
// Configuration macro: DCT_ROUND_EN -- when defined, each coefficient is rounded,
//   shifted down by 2*(COEF_W-1) and saturated to signed OUT_W; otherwise the raw
//   full-precision column-pass result is emitted.
module dct_2d_stream
   import dct_pkg::*;
#(
   parameter int N      = 8,
   parameter int IN_W   = 9,
   parameter int COEF_W = 12,
   parameter int OUT_W  = 16
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [N*IN_W-1:0]                             in_row,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [N*dout_w(N, IN_W, COEF_W, OUT_W)-1:0]   out_row,
   output logic                                          out_last
);

   localparam int ROW_W  = row_w(N, IN_W, COEF_W);
   localparam int FULL_W = full_w(N, IN_W, COEF_W);
   localparam int DOUT_W = dout_w(N, IN_W, COEF_W, OUT_W);
   localparam int CNT_W  = $clog2(N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   dct_state_e       r_state;
   // Shared index: input row r in LOAD, column j in COL, output row k in OUT.
   logic [CNT_W-1:0] r_cnt;

   logic [ROW_W-1:0]    r_tbuf [N][N];
   logic [DOUT_W-1:0]   r_obuf [N][N];

   logic [N*ROW_W-1:0]  w_row_dct;
   logic [N*ROW_W-1:0]  w_col_vec;
   logic [N*FULL_W-1:0] w_col_dct;
   logic [DOUT_W-1:0]   w_col_fmt [N];
   logic                w_in_fire;
   logic                w_out_fire;

   assign in_ready   = (r_state == StLoad);
   assign out_valid  = (r_state == StOut);
   assign out_last   = out_valid && (r_cnt == CNT_LAST);
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = out_valid && out_ready;

   // ---------------------------------------------------------------- control
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StLoad;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            StLoad: begin
               if (w_in_fire) begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_LAST) r_state <= StCol;
               end
            end
            StCol: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_LAST) r_state <= StOut;
            end
            StOut: begin
               if (w_out_fire) begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_LAST) r_state <= StLoad;
               end
            end
            default: begin
               r_state <= StLoad;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- row pass
   dct_1d #(
      .N      (N),
      .IN_W   (IN_W),
      .COEF_W (COEF_W)
   ) u_row_dct (
      .i_vec (in_row),
      .o_vec (w_row_dct)
   );

   // ---------------------------------------------------------------- column pass
   always_comb begin
      w_col_vec = '0;
      for (int i = 0; i < N; i++) begin
         w_col_vec[i*ROW_W +: ROW_W] = r_tbuf[i][r_cnt];
      end
   end

   dct_1d #(
      .N      (N),
      .IN_W   (ROW_W),
      .COEF_W (COEF_W)
   ) u_col_dct (
      .i_vec (w_col_vec),
      .o_vec (w_col_dct)
   );

   for (genvar g = 0; g < N; g++) begin : g_fmt
`ifdef DCT_ROUND_EN
      localparam logic signed [FULL_W:0] RND_BIAS = (FULL_W + 1)'(1) <<< (2 * COEF_W - 3);
      localparam logic signed [FULL_W:0] SAT_MAX  =
         ((FULL_W + 1)'(1) <<< (OUT_W - 1)) - (FULL_W + 1)'(1);
      localparam logic signed [FULL_W:0] SAT_MIN  = -SAT_MAX - (FULL_W + 1)'(1);

      logic signed [FULL_W-1:0] w_raw;
      logic signed [FULL_W:0]   w_biased;
      logic signed [FULL_W:0]   w_shifted;
      logic [DOUT_W-1:0]        w_fmt;

      assign w_raw     = w_col_dct[g*FULL_W +: FULL_W];
      // One guard bit so adding the rounding bias cannot wrap.
      assign w_biased  = (FULL_W + 1)'(w_raw) + RND_BIAS;
      assign w_shifted = w_biased >>> (2 * (COEF_W - 1));

      always_comb begin
         if (w_shifted > SAT_MAX) begin
            w_fmt = SAT_MAX[DOUT_W-1:0];
         end else if (w_shifted < SAT_MIN) begin
            w_fmt = SAT_MIN[DOUT_W-1:0];
         end else begin
            w_fmt = w_shifted[DOUT_W-1:0];
         end
      end
      assign w_col_fmt[g] = w_fmt;
`else
      assign w_col_fmt[g] = w_col_dct[g*FULL_W +: FULL_W];
`endif
   end

   // ---------------------------------------------------------------- buffers
   // Data storage only; stale contents are always overwritten before being read.
   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         for (int l = 0; l < N; l++) begin
            r_tbuf[r_cnt][l] <= w_row_dct[l*ROW_W +: ROW_W];
         end
      end
      if (r_state == StCol) begin
         for (int k = 0; k < N; k++) begin
            r_obuf[k][r_cnt] <= w_col_fmt[k];
         end
      end
   end

   always_comb begin
      out_row = '0;
      for (int l = 0; l < N; l++) begin
         out_row[l*DOUT_W +: DOUT_W] = r_obuf[r_cnt][l];
      end
   end

endmodule

// File: tb/tb_dct_2d_stream.sv
// Self-checking bench for dct_2d_stream (N=8, IN_W=9, COEF_W=12, OUT_W=16).
// Expected rows are pushed to a queue when a block is driven and compared as the DUT
// emits them. Honours DCT_ROUND_EN the same way as the design.
module tb_dct_2d_stream;

   localparam int N      = 8;
   localparam int IN_W   = 9;
   localparam int COEF_W = 12;
   localparam int OUT_W  = 16;
   localparam int FULL_W = 2 * COEF_W + IN_W + 2 * $clog2(N);
`ifdef DCT_ROUND_EN
   localparam int     DOUT_W = OUT_W;
   localparam longint K100   = 800;
`else
   localparam int     DOUT_W = FULL_W;
   localparam longint K100   = 64'd3354726400;
`endif

   logic                  clk;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [N*IN_W-1:0]     in_row;
   logic                  out_valid;
   logic                  out_ready;
   logic [N*DOUT_W-1:0]   out_row;
   logic                  out_last;

   dct_2d_stream #(
      .N      (N),
      .IN_W   (IN_W),
      .COEF_W (COEF_W),
      .OUT_W  (OUT_W)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_row    (in_row),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_row   (out_row),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int  coef [N][N];
   int  blk  [N][N];
   logic [N*DOUT_W-1:0] exp_q [$];

   int  cyc       = 0;
   int  last_hs   = 0;
   int  mon_row   = 0;
   int  n_stall   = 0;
   bit  prev_ov   = 1'b0;
   bit  stall_en  = 1'b0;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   function automatic int tb_coef(input int k, input int n);
      real a;
      real v;
      a = (k == 0) ? $sqrt(1.0 / N) : $sqrt(2.0 / N);
      v = 2048.0 * a * $cos(3.14159265358979 * real'((2 * n + 1) * k) / real'(2 * N));
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
   endfunction

   function automatic longint fmt(input longint z);
`ifdef DCT_ROUND_EN
      longint t;
      longint mx;
      mx = (longint'(1) << (OUT_W - 1)) - 1;
      t  = (z + (longint'(1) << (2 * COEF_W - 3))) >>> (2 * (COEF_W - 1));
      if (t > mx) t = mx;
      if (t < -mx - 1) t = -mx - 1;
      return t;
`else
      return z;
`endif
   endfunction

   task automatic fill_const(input int v);
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) blk[i][j] = v;
   endtask

   task automatic fill_rand();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) blk[i][j] = int'($urandom_range(0, 511)) - 256;
   endtask

   // Independent reference: separable DCT, rows then columns, exact 64-bit arithmetic.
   task automatic push_model();
      longint y [N][N];
      longint z;
      logic [63:0] zz;
      logic [N*DOUT_W-1:0] v;
      for (int i = 0; i < N; i++)
         for (int l = 0; l < N; l++) begin
            y[i][l] = 0;
            for (int j = 0; j < N; j++) y[i][l] += longint'(coef[l][j]) * longint'(blk[i][j]);
         end
      for (int k = 0; k < N; k++) begin
         v = '0;
         for (int l = 0; l < N; l++) begin
            z = 0;
            for (int i = 0; i < N; i++) z += longint'(coef[k][i]) * y[i][l];
            zz = fmt(z);
            v[l*DOUT_W +: DOUT_W] = zz[DOUT_W-1:0];
         end
         exp_q.push_back(v);
      end
   endtask

   // Flat block: only the DC term is non-zero.
   task automatic push_dc(input longint dc);
      logic [N*DOUT_W-1:0] v;
      logic [63:0] d;
      d = dc;
      for (int k = 0; k < N; k++) begin
         v = '0;
         if (k == 0) v[DOUT_W-1:0] = d[DOUT_W-1:0];
         exp_q.push_back(v);
      end
   endtask

   task automatic drive_row(input int i);
      int t;
      t = 0;
      in_valid = 1'b1;
      for (int j = 0; j < N; j++) in_row[j*IN_W +: IN_W] = blk[i][j][IN_W-1:0];
      @(negedge clk);
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) check("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_block(input bit gaps);
      for (int i = 0; i < N; i++) begin
         drive_row(i);
         if (gaps) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Output monitor, sampling on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (in_valid && in_ready) last_hs = cyc;
         if (out_valid && !prev_ov) check("latency", cyc - last_hs, N + 1);
         prev_ov = out_valid;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_row", 1, 0);
            end else begin
               check($sformatf("row%0d", mon_row), out_row, exp_q[0]);
               check("out_last", out_last, (mon_row == N - 1));
               check("in_ready_busy", in_ready, 0);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  mon_row = (mon_row == N - 1) ? 0 : mon_row + 1;
               end else begin
                  n_stall++;
               end
            end
         end
      end
   end

   // Back-pressure: hold out_ready low for 5 cycles while row 3 is presented.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_en && out_valid && mon_row == 3) begin
            out_ready = 1'b0;
            repeat (5) begin
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
            stall_en  = 1'b0;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_row   = '0;
      for (int k = 0; k < N; k++) for (int n = 0; n < N; n++) coef[k][n] = tb_coef(k, n);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // All-zero block.
      fill_const(0);
      send_block(1'b0);
      push_dc(0);
      wait_drain();

      // Flat 100 block: DC only.
      fill_const(100);
      send_block(1'b0);
      push_dc(K100);
      wait_drain();

      // Random block back-to-back, then the same block with in_valid toggling.
      fill_rand();
      send_block(1'b0);
      push_model();
      wait_drain();
      send_block(1'b1);
      push_model();
      wait_drain();

      // Extremes of the input range.
      fill_const(-256);
      send_block(1'b0);
      push_model();
      wait_drain();
      fill_const(255);
      send_block(1'b1);
      push_model();
      wait_drain();

      // Output back-pressure at row 3.
      fill_rand();
      n_stall  = 0;
      stall_en = 1'b1;
      send_block(1'b0);
      push_model();
      wait_drain();
      check("stall_cycles", n_stall, 5);

      // Reset after four rows: the partial block must vanish.
      fill_rand();
      for (int i = 0; i < 4; i++) drive_row(i);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      fill_const(100);
      send_block(1'b0);
      push_dc(K100);
      wait_drain();
      repeat (20) @(posedge clk);
      #1;
      check("no_extra_rows", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dct_2d_stream.md
DCT_2D_STREAM -- requirements
Module: dct_2d_stream

Interface
REQ-001 SHALL have parameter N, default 8, block edge length (power of two, 4..16).
REQ-002 SHALL have parameter IN_W, default 9, signed input sample width.
REQ-003 SHALL have parameter COEF_W, default 12, signed cosine coefficient width (Q1.COEF_W-1).
REQ-004 SHALL have parameter OUT_W, default 16, rounded output width (used only under DCT_ROUND_EN).
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  input row valid.
REQ-008 SHALL have port in_ready  output  1  block accepts an input row.
REQ-009 SHALL have port in_row  input  N*IN_W  one signed row, element 0 in LSBs.
REQ-010 SHALL have port out_valid  output  1  output row valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts output row.
REQ-012 SHALL have port out_row  output  N*DOUT_W  one coefficient row, element 0 in LSBs.
REQ-013 SHALL have port out_last  output  1  high with final row (row N-1) of a block.

Function
REQ-014 SHALL implement FSM LOAD -> COL -> OUT -> LOAD; reset state LOAD.
REQ-015 LOAD: in_ready=1; each in_valid&&in_ready beat applies 1-D DCT to in_row, writes result into transpose buffer row r, r increments; after beat r=N-1, next state COL.
REQ-016 in_valid gaps in LOAD SHALL stall with no state change; in_row sampled only on handshake.
REQ-017 COL: in_ready=0; exactly N cycles, cycle j applies 1-D DCT to buffer column j and writes output buffer column j; then OUT.
REQ-018 OUT: out_valid=1, out_row = output row k; k advances only on out_valid&&out_ready; out_last=1 when k=N-1; after that beat, LOAD with r=0.
REQ-019 out_row and out_last SHALL hold stable while out_valid&&!out_ready.
REQ-020 Latency: first out_valid SHALL assert exactly N+1 cycles after the handshake of input row N-1.
REQ-021 No block overlap: in_ready SHALL be 0 in COL and OUT.
REQ-022 Row pass width ROW_W = IN_W+COEF_W+clog2(N); column pass width FULL_W = ROW_W+COEF_W+clog2(N); no truncation inside the block.
REQ-023 Coefficient C[k][n] = round-half-away(2^(COEF_W-1)*a(k)*cos((2n+1)k*pi/(2N))), a(0)=sqrt(1/N), else sqrt(2/N); computed at elaboration.

Reset
REQ-024 On rst: FSM=LOAD, r=0, j=0, k=0, in_ready=1 after release, out_valid=0, out_last=0; buffers need not clear.
REQ-025 rst mid-block SHALL discard partial data; first post-reset handshake is row 0 of a new block.

Configuration
REQ-026 Macro DCT_ROUND_EN defined: DOUT_W=OUT_W; each output = FULL_W result + 2^(2*COEF_W-3), arithmetic shift right 2*(COEF_W-1), saturate to signed OUT_W.
REQ-027 DCT_ROUND_EN undefined: DOUT_W=FULL_W; raw full-precision result, OUT_W ignored.

Structure
REQ-028 Package dct_pkg SHALL hold the FSM state enum, clog2-based width functions, and coefficient-table generation function.
REQ-029 Sub-module dct_1d (parameters N, IN_W, COEF_W; combinational N-point matrix-vector product) SHALL be instantiated for both passes, time-shared or twice.

Verification
REQ-030 All-zero block -> 8 output rows all 0, out_last on row 7.
REQ-031 All-100 block, N=8, COEF_W=12, DCT_ROUND_EN -> out[0][0]=800, all other 63 coefficients 0.
REQ-032 Same block without DCT_ROUND_EN -> out[0][0]=3354726400, others 0.
REQ-033 out_ready held low 5 cycles in OUT at row 3 -> row 3 stable throughout, no row skipped, in_ready stays 0.
REQ-034 rst pulsed after 4 input rows, then full all-100 block -> single output block, out[0][0]=800.
REQ-035 in_valid toggling 1/0 every cycle -> identical output to back-to-back input; first out_valid 9 cycles after last input handshake.
